scsi_dma_byte_sm: RTL and testbench

- SCSI-side DMA engine that moves single bytes between the WD33C93 and the 8 x 32-bit FIFO.
- Sits directly upstream of the FIFO for SCSI-to-memory transfers, driving LBYTE_, INCBO, INCNI and INCFIFO.
- Sits directly downstream of the FIFO for memory-to-SCSI transfers: selects the byte lane from OD, and drives INCBO, INCNO and DECFIFO.
- Generates the DACK_/RE_/WE_ handshake to the SCSI controller.

---
 rtl/scsi_dma_byte_sm_pkg.sv | 28 ++
 rtl/scsi_dma_byte_sm_lane_mux.sv | 20 ++
 rtl/scsi_dma_byte_sm.sv | 171 +++++++++++++++++
 tb/tb_scsi_dma_byte_sm.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scsi_dma_byte_sm_pkg.sv
// Shared definitions for the SCSI-side single-byte DMA engine:
// state encoding, direction encoding and the OD byte-lane selector.
package scsi_dma_byte_sm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic DIR_TO_SCSI = 1'b1;
  localparam logic DIR_TO_MEM  = 1'b0;

  // Byte pointer 0 addresses the most significant lane of the FIFO long word.
  function automatic logic [7:0] lane_sel(input logic [31:0] od, input logic [1:0] bo);
    logic [7:0] b;
    b = od[31:24];
    case (bo)
      2'b00:   b = od[31:24];
      2'b01:   b = od[23:16];
      2'b10:   b = od[15:8];
      default: b = od[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/scsi_dma_byte_sm_lane_mux.sv
// Registered 4:1 byte-lane select of the FIFO output word onto the SCSI data bus.
module scsi_lane_mux
  import scsi_dma_byte_sm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [1:0]  bo,
  input  logic [31:0] od,
  output logic [7:0]  sd_out
);

  always_ff @(posedge clk) begin
    if (rst)
      sd_out <= '0;
    else if (load)
      sd_out <= lane_sel(od, bo);
  end

endmodule

// File: rtl/scsi_dma_byte_sm.sv
// SCSI-side DMA byte engine: DACK_/RE_/WE_ handshake with the WD33C93 and
// byte/word pointer pulses towards the 8 x 32-bit FIFO.
module scsi_dma_byte_sm #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DMAENA,
  input  logic        DDIR,
  input  logic        DREQ_,
  input  logic        FIFOFULL,
  input  logic        FIFOEMPTY,
  input  logic        BOEQ3,
  input  logic        BO0,
  input  logic        BO1,
  input  logic [31:0] OD,
  output logic        DACK_,
  output logic        RE_,
  output logic        WE_,
  output logic        LBYTE_,
  output logic        INCBO,
  output logic        INCNI,
  output logic        INCNO,
  output logic        INCFIFO,
  output logic        DECFIFO,
  output logic [7:0]  SD_OUT,
  output logic        SD_OE,
  output logic        BUSY
);
  import scsi_dma_byte_sm_pkg::*;

  localparam logic [2:0] SETUP_LAST  = 3'(SETUP_CYCLES - 1);
  localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic       dir_q, dir_nxt;
  logic       b3_q, b3_nxt;
  logic       go;

  logic dack_nxt, re_nxt, we_nxt, lbyte_nxt;
  logic incbo_nxt, incni_nxt, incno_nxt, incfifo_nxt, decfifo_nxt;
  logic sd_oe_nxt, busy_nxt;

  assign go = DMAENA && !DREQ_ && (DDIR ? !FIFOEMPTY : !FIFOFULL);

  // Outputs are registered from the next-state decode so every strobe and
  // pulse comes straight off a flop, aligned with the state it belongs to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      dir_q   <= DIR_TO_MEM;
      b3_q    <= 1'b0;
      DACK_   <= 1'b1;
      RE_     <= 1'b1;
      WE_     <= 1'b1;
      LBYTE_  <= 1'b1;
      INCBO   <= 1'b0;
      INCNI   <= 1'b0;
      INCNO   <= 1'b0;
      INCFIFO <= 1'b0;
      DECFIFO <= 1'b0;
      SD_OE   <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      dir_q   <= dir_nxt;
      b3_q    <= b3_nxt;
      DACK_   <= dack_nxt;
      RE_     <= re_nxt;
      WE_     <= we_nxt;
      LBYTE_  <= lbyte_nxt;
      INCBO   <= incbo_nxt;
      INCNI   <= incni_nxt;
      INCNO   <= incno_nxt;
      INCFIFO <= incfifo_nxt;
      DECFIFO <= decfifo_nxt;
      SD_OE   <= sd_oe_nxt;
      BUSY    <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir_q;
    b3_nxt    = b3_q;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = SETUP;
          dir_nxt   = DDIR;
          cnt_nxt   = '0;
        end
      end
      SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_nxt = STROBE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      STROBE: begin
        if (cnt == STROBE_LAST) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
          b3_nxt    = BOEQ3;
        end else begin
          cnt_nxt = cnt + 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    dack_nxt    = 1'b1;
    re_nxt      = 1'b1;
    we_nxt      = 1'b1;
    lbyte_nxt   = 1'b1;
    incbo_nxt   = 1'b0;
    incni_nxt   = 1'b0;
    incno_nxt   = 1'b0;
    incfifo_nxt = 1'b0;
    decfifo_nxt = 1'b0;
    sd_oe_nxt   = 1'b0;
    busy_nxt    = (state_nxt != IDLE);
    case (state_nxt)
      SETUP: begin
        dack_nxt  = 1'b0;
        sd_oe_nxt = (dir_nxt == DIR_TO_SCSI);
      end
      STROBE: begin
        dack_nxt  = 1'b0;
        sd_oe_nxt = (dir_nxt == DIR_TO_SCSI);
        if (dir_nxt == DIR_TO_SCSI) begin
          we_nxt = 1'b0;
        end else begin
          re_nxt    = 1'b0;
          lbyte_nxt = 1'b0;
        end
      end
      RELEASE: begin
        incbo_nxt   = 1'b1;
        sd_oe_nxt   = (dir_nxt == DIR_TO_SCSI);
        incni_nxt   = (dir_nxt == DIR_TO_MEM)  && b3_nxt;
        incfifo_nxt = (dir_nxt == DIR_TO_MEM)  && b3_nxt;
        incno_nxt   = (dir_nxt == DIR_TO_SCSI) && b3_nxt;
        decfifo_nxt = (dir_nxt == DIR_TO_SCSI) && b3_nxt;
      end
      default: ;
    endcase
  end

  scsi_lane_mux u_lane_mux (
    .clk    (CLK),
    .rst    (RST),
    .load   ((state_nxt == SETUP) && (dir_nxt == DIR_TO_SCSI)),
    .bo     ({BO1, BO0}),
    .od     (OD),
    .sd_out (SD_OUT)
  );

endmodule

// File: tb/tb_scsi_dma_byte_sm.sv
// Scoreboard bench for scsi_dma_byte_sm: the driver queues one expected byte
// record per transfer, the monitor checks each completed byte at its INCBO pulse.
module tb_scsi_dma_byte_sm;

  localparam int unsigned SETUP_CYCLES  = 1;
  localparam int unsigned STROBE_CYCLES = 2;
  localparam int BYTE_PERIOD = 1 + SETUP_CYCLES + STROBE_CYCLES + 1;

  logic        CLK = 1'b0, RST = 1'b1, DMAENA = 1'b0, DDIR = 1'b0, DREQ_ = 1'b1;
  logic        FIFOFULL = 1'b0, FIFOEMPTY = 1'b0, BOEQ3 = 1'b0, BO0 = 1'b0, BO1 = 1'b0;
  logic [31:0] OD = '0;
  logic        DACK_, RE_, WE_, LBYTE_, INCBO, INCNI, INCNO, INCFIFO, DECFIFO, SD_OE, BUSY;
  logic [7:0]  SD_OUT;

  scsi_dma_byte_sm #(.SETUP_CYCLES(SETUP_CYCLES), .STROBE_CYCLES(STROBE_CYCLES)) dut (
    .CLK(CLK), .RST(RST), .DMAENA(DMAENA), .DDIR(DDIR), .DREQ_(DREQ_),
    .FIFOFULL(FIFOFULL), .FIFOEMPTY(FIFOEMPTY), .BOEQ3(BOEQ3), .BO0(BO0), .BO1(BO1),
    .OD(OD), .DACK_(DACK_), .RE_(RE_), .WE_(WE_), .LBYTE_(LBYTE_), .INCBO(INCBO),
    .INCNI(INCNI), .INCNO(INCNO), .INCFIFO(INCFIFO), .DECFIFO(DECFIFO),
    .SD_OUT(SD_OUT), .SD_OE(SD_OE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       dir;
    logic [7:0] data;
    logic       word;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   bo       = 0;
  logic b2b_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Reference: the byte at pointer bo is the bo-th byte counting from the MSB.
  function automatic exp_t model(input logic dir, input logic [31:0] od, input int p);
    exp_t e;
    e.dir  = dir;
    e.word = (p == 3);
    e.data = dir ? 8'((od >> (8 * (3 - p))) & 32'hff) : 8'h00;
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_bo();
    logic [1:0] b;
    b = 2'(bo);
    BO0 = b[0];
    BO1 = b[1];
    BOEQ3 = (bo == 3);
  endtask

  // which: 0 = DACK_ low, 1 = INCBO high, 2 = RE_ low
  task automatic wait_event(input int which, input string name);
    int n;
    n = 0;
    while (!((which == 0 && !DACK_) || (which == 1 && INCBO) || (which == 2 && !RE_)) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic issue_byte(input logic dir, input logic [31:0] od, input logic drop_ena);
    DDIR = dir;
    OD = od;
    drive_bo();
    FIFOFULL  = dir ? 1'($urandom) : 1'b0;
    FIFOEMPTY = dir ? 1'b0 : 1'($urandom);
    DMAENA = 1'b1;
    DREQ_ = 1'b0;
    exp_q.push_back(model(dir, od, bo));
    tick();
    wait_event(0, "dack");
    DREQ_ = 1'b1;
    if (drop_ena) DMAENA = 1'b0;
    FIFOFULL  = 1'($urandom);
    FIFOEMPTY = 1'($urandom);
    wait_event(1, "incbo");
    bo = (bo + 1) % 4;
    drive_bo();
    repeat ($urandom_range(0, 3)) tick();
  endtask

  task automatic flow_test(input logic dir);
    DDIR = dir;
    OD = $urandom;
    drive_bo();
    DMAENA = 1'b1;
    FIFOFULL = !dir;
    FIFOEMPTY = dir;
    DREQ_ = 1'b0;
    repeat (4) begin
      tick();
      check("blocked_dack", 32'(DACK_), 32'd1);
      check("blocked_busy", 32'(BUSY), 32'd0);
    end
    exp_q.push_back(model(dir, OD, bo));
    FIFOFULL = 1'b0;
    FIFOEMPTY = 1'b0;
    tick();
    check("unblocked_dack", 32'(DACK_), 32'd0);
    DREQ_ = 1'b1;
    wait_event(1, "flow_incbo");
    bo = (bo + 1) % 4;
    drive_bo();
    tick();
  endtask

  // Monitor state
  int         cyc = 0, dack_cnt = 0, re_cnt = 0, we_cnt = 0, lb_cnt = 0, last_fall = -1;
  logic       prev_dack = 1'b1, prev_lbyte = 1'b1, post_rel = 1'b0, oe_setup = 1'b0;
  logic [7:0] sd_setup = '0, sd_strobe = '0;
  exp_t       mon_e;

  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      dack_cnt = 0; re_cnt = 0; we_cnt = 0; lb_cnt = 0; last_fall = -1;
      prev_dack = 1'b1; prev_lbyte = 1'b1; post_rel = 1'b0;
    end else begin
      if (post_rel) begin
        check("post_release_busy", 32'(BUSY), 32'd0);
        check("post_release_sd_oe", 32'(SD_OE), 32'd0);
        check("post_release_pulses", 32'({INCBO, INCNI, INCFIFO, INCNO, DECFIFO}), 32'd0);
        post_rel = 1'b0;
      end else if (!INCBO && (INCNI || INCFIFO || INCNO || DECFIFO)) begin
        check("stray_word_pulse", 32'({INCNI, INCFIFO, INCNO, DECFIFO}), 32'd0);
      end
      if (!DACK_ && prev_dack) begin
        sd_setup = SD_OUT;
        oe_setup = SD_OE;
        if (b2b_mode) begin
          if (last_fall >= 0) check("byte_period", 32'(cyc - last_fall), 32'(BYTE_PERIOD));
          last_fall = cyc;
        end else begin
          last_fall = -1;
        end
      end
      if (!DACK_) dack_cnt++;
      if (!RE_) re_cnt++;
      if (!WE_) begin
        we_cnt++;
        sd_strobe = SD_OUT;
      end
      if (!LBYTE_) lb_cnt++;
      if (INCBO) begin
        if (exp_q.size() == 0) begin
          check("unexpected_incbo", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("dack_low_cycles", 32'(dack_cnt), 32'(SETUP_CYCLES + STROBE_CYCLES));
          check("re_low_cycles", 32'(re_cnt), mon_e.dir ? 32'd0 : 32'(STROBE_CYCLES));
          check("we_low_cycles", 32'(we_cnt), mon_e.dir ? 32'(STROBE_CYCLES) : 32'd0);
          check("lbyte_low_cycles", 32'(lb_cnt), mon_e.dir ? 32'd0 : 32'(STROBE_CYCLES));
          check("release_strobes_high", 32'({DACK_, RE_, WE_, LBYTE_}), 32'hf);
          check("release_busy", 32'(BUSY), 32'd1);
          check("word_pulses", 32'({INCNI, INCFIFO, INCNO, DECFIFO}),
                32'({!mon_e.dir && mon_e.word, !mon_e.dir && mon_e.word,
                     mon_e.dir && mon_e.word, mon_e.dir && mon_e.word}));
          if (mon_e.dir) begin
            check("sd_out_setup", 32'(sd_setup), 32'(mon_e.data));
            check("sd_out_strobe", 32'(sd_strobe), 32'(mon_e.data));
            check("sd_oe_setup", 32'(oe_setup), 32'd1);
            check("sd_oe_release_hold", 32'(SD_OE), 32'd1);
          end else begin
            check("lbyte_rise_before_incbo", 32'(prev_lbyte), 32'd0);
          end
        end
        dack_cnt = 0; re_cnt = 0; we_cnt = 0; lb_cnt = 0;
        post_rel = 1'b1;
      end
      prev_dack = DACK_;
      prev_lbyte = LBYTE_;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks made", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int incni_cnt;
    RST = 1'b1;
    tick();
    tick();
    check("reset_strobes", 32'({DACK_, RE_, WE_, LBYTE_}), 32'hf);
    check("reset_pulses", 32'({INCBO, INCNI, INCNO, INCFIFO, DECFIFO, SD_OE, BUSY}), 32'd0);
    check("reset_sd_out", 32'(SD_OUT), 32'd0);
    RST = 1'b0;
    tick();

    bo = 0;
    issue_byte(1'b0, $urandom, 1'b0);
    bo = 3;
    issue_byte(1'b0, $urandom, 1'b0);

    bo = 0;
    for (int i = 0; i < 4; i++) issue_byte(1'b1, 32'hA1B2C3D4, 1'b0);

    flow_test(1'b0);
    flow_test(1'b1);

    // DMAENA dropped mid-strobe: byte must still complete in full
    DDIR = 1'b0; drive_bo(); FIFOFULL = 1'b0; DMAENA = 1'b1; DREQ_ = 1'b0;
    exp_q.push_back(model(1'b0, 32'd0, bo));
    wait_event(2, "abort_re");
    DMAENA = 1'b0;
    DREQ_ = 1'b1;
    wait_event(1, "abort_incbo");
    bo = (bo + 1) % 4;
    drive_bo();
    repeat (4) tick();

    // RST mid-strobe: no pulse for the aborted byte, pointer unchanged
    DDIR = 1'b0; FIFOFULL = 1'b0; DMAENA = 1'b1; DREQ_ = 1'b0;
    wait_event(2, "rst_abort_re");
    RST = 1'b1;
    DREQ_ = 1'b1;
    tick();
    check("rst_abort_strobes", 32'({DACK_, RE_, WE_, LBYTE_}), 32'hf);
    check("rst_abort_incbo", 32'(INCBO), 32'd0);
    check("rst_abort_busy", 32'(BUSY), 32'd0);
    tick();
    check("rst_abort_incbo_hold", 32'(INCBO), 32'd0);
    RST = 1'b0;
    repeat (3) tick();

    // Back-to-back: eight bytes with DREQ_ held low
    bo = 0; drive_bo();
    DDIR = 1'b0; FIFOFULL = 1'b0; FIFOEMPTY = 1'b0; DMAENA = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(model(1'b0, 32'd0, i % 4));
    b2b_mode = 1'b1;
    incni_cnt = 0;
    DREQ_ = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      wait_event(1, "b2b_incbo");
      if (INCNI) incni_cnt++;
      bo = (bo + 1) % 4;
      drive_bo();
      if (i == 7) DREQ_ = 1'b1;
    end
    check("b2b_incni_count", 32'(incni_cnt), 32'd2);
    tick();
    b2b_mode = 1'b0;
    tick();

    repeat (40) issue_byte(1'($urandom), $urandom, 1'($urandom));

    repeat (6) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
